// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 16-bit multiply/divide unit with LO/HI result
// registers and status flags. One quotient/product bit per CALC cycle.
//
// Handshake: start is a request that is taken only on an edge where busy=0
// and reset=1. Once taken, busy stays high until the WRITE cycle ends.
// done, write_lo and write_hi pulse together for exactly that WRITE cycle,
// and they mark the cycle in which value_lo/value_hi and the flags first
// carry the new result. A start seen while busy=1 (WRITE included) is dropped.
// Nothing is queued.
module muldiv_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             write_lo,
    output logic             write_hi,
    output logic [WIDTH-1:0] value_lo,
    output logic [WIDTH-1:0] value_hi,
    output logic             negative,
    output logic             overflow,
    output logic             carry,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // op[1] selects divide, op[0] selects signed
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;        // raw dividend, needed for divide-by-zero remainder
    logic [WIDTH-1:0] m_q;        // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] hi_q;       // product high half / partial remainder
    logic [WIDTH-1:0] lo_q;       // multiplier shifting out / quotient shifting in
    logic [CW-1:0]    cnt_q;
    logic             sign_q;     // result sign for signed ops
    logic             a_neg_q;    // dividend sign, which the remainder follows
    logic             b_zero_q;
    logic             ovf_case_q; // most-negative / -1 signed divide

    logic             accept;
    logic             finish;
    logic             a_neg_in, b_neg_in;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   f_lo, f_hi;
    logic               f_neg, f_ovf, f_cy, f_zr;

    assign accept   = (state_q == S_IDLE) && start;
    assign finish   = (state_q == S_CALC) && (cnt_q == LAST);

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_WRITE);
    assign write_lo  = (state_q == S_WRITE);
    assign write_hi  = (state_q == S_WRITE);
    assign dbg_state = state_q;

    // Operand magnitudes for the signed variants; 16'h8000 maps onto itself,
    // which is the correct unsigned magnitude.
    assign a_neg_in = op[0] & operand_a[WIDTH-1];
    assign b_neg_in = op[0] & operand_b[WIDTH-1];
    assign a_mag_in = a_neg_in ? -operand_a : operand_a;
    assign b_mag_in = b_neg_in ? -operand_b : operand_b;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: 17 CALC cycles (16 iterations plus the result fix-up)
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)  state_d = S_CALC;
            S_CALC:  if (finish) state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One iteration step: shift-add for multiply, restoring step for divide
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, m_q});
        div_diff  = div_shift - {1'b0, m_q};
    end

    // Operand capture on acceptance and the iterative datapath during CALC
    always_ff @(posedge clock) begin
        if (!reset) begin
            op_q       <= '0;
            a_q        <= '0;
            m_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            a_neg_q    <= 1'b0;
            b_zero_q   <= 1'b0;
            ovf_case_q <= 1'b0;
        end else if (accept) begin
            op_q       <= op;
            a_q        <= operand_a;
            m_q        <= op[1] ? b_mag_in : a_mag_in;
            lo_q       <= op[1] ? a_mag_in : b_mag_in;
            hi_q       <= '0;
            cnt_q      <= '0;
            sign_q     <= a_neg_in ^ b_neg_in;
            a_neg_q    <= a_neg_in;
            b_zero_q   <= (operand_b == '0);
            ovf_case_q <= (op == 2'b11) && (operand_a == {1'b1, {(WIDTH-1){1'b0}}})
                          && (operand_b == '1);
        end else if ((state_q == S_CALC) && !finish) begin
            cnt_q <= cnt_q + 1'b1;
            if (!op_q[1]) begin
                hi_q <= mul_sum[WIDTH:1];
                lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
            end else if (div_ge) begin
                hi_q <= div_diff[WIDTH-1:0];
                lo_q <= {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_q <= div_shift[WIDTH-1:0];
                lo_q <= {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Result fix-up: sign restoration, divide-by-zero override and flags
    always_comb begin
        prod = {hi_q, lo_q};
        quo  = lo_q;
        rem  = hi_q;
        f_lo = '0;
        f_hi = '0;
        if (!op_q[1]) begin
            if (op_q[0] && sign_q) {f_hi, f_lo} = -prod;
            else                   {f_hi, f_lo} = prod;
        end else begin
            if (op_q[0]) begin
                if (sign_q)  quo = -lo_q;
                if (a_neg_q) rem = -hi_q;
            end
            if (b_zero_q) begin
                quo = '1;
                rem = a_q;
            end
            f_lo = quo;
            f_hi = rem;
        end
        f_ovf = op_q[1] & (b_zero_q | ovf_case_q);
        f_zr  = op_q[1] ? (f_lo == '0) : ({f_hi, f_lo} == '0);
        f_neg = op_q[0] & (op_q[1] ? f_lo[WIDTH-1] : f_hi[WIDTH-1]);
        if (op_q[1])      f_cy = 1'b0;
        else if (op_q[0]) f_cy = (f_hi != {WIDTH{f_lo[WIDTH-1]}});
        else              f_cy = (f_hi != '0);
    end

    // Result registers: loaded on entry to WRITE, held until the next one
    always_ff @(posedge clock) begin
        if (!reset) begin
            value_lo <= '0;
            value_hi <= '0;
            negative <= 1'b0;
            overflow <= 1'b0;
            carry    <= 1'b0;
            zero     <= 1'b0;
        end else if (finish) begin
            value_lo <= f_lo;
            value_hi <= f_hi;
            negative <= f_neg;
            overflow <= f_ovf;
            carry    <= f_cy;
            zero     <= f_zr;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. The driver pushes the
// reference result and the edge at which it must appear; the monitor pops
// on every write strobe.
module tb_muldiv_unit;

  localparam int W  = 16;
  localparam int EW = 2*W + 4;  // {value_hi, value_lo, negative, overflow, carry, zero}

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] operand_a, operand_b;
  logic         busy, done, write_lo, write_hi;
  logic [W-1:0] value_lo, value_hi;
  logic         negative, overflow, carry, zero;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  bit prev_strobe = 1'b0;

  logic [EW-1:0] exp_q[$];
  int            due_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .write_lo(write_lo), .write_hi(write_hi),
    .value_lo(value_lo), .value_hi(value_hi),
    .negative(negative), .overflow(overflow), .carry(carry), .zero(zero),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / edge counter ----------------
  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    edge_cnt = edge_cnt + 1;
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint ua, ub, sa, sb;
    logic [2*W-1:0] p;
    logic [W-1:0] hi, lo;
    logic neg, ovf, cy, zr;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ovf = 1'b0;
    if (o[1] == 1'b0) begin
      p  = (o[0]) ? 32'(sa * sb) : 32'(ua * ub);
      hi = p[2*W-1:W];
      lo = p[W-1:0];
      zr = (p == 0);
      neg = o[0] && hi[W-1];
      cy = o[0] ? (hi != {W{lo[W-1]}}) : (hi != 0);
    end else begin
      if (b == 0) begin
        lo = 16'hFFFF; hi = a; ovf = 1'b1;
      end else if (o[0] && a == 16'h8000 && b == 16'hFFFF) begin
        lo = 16'h8000; hi = 16'h0000; ovf = 1'b1;
      end else if (o[0]) begin
        lo = 16'(sa / sb);   // truncates toward zero
        hi = 16'(sa % sb);   // remainder follows dividend sign
      end else begin
        lo = 16'(ua / ub);
        hi = 16'(ua % ub);
      end
      zr  = (lo == 0);
      neg = o[0] && lo[W-1];
      cy  = 1'b0;
    end
    return {hi, lo, neg, ovf, cy, zr};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    @(negedge clock);
    if (reset === 1'b1) begin
      if (write_lo || write_hi || done) begin
        check("strobe_align", {write_lo, write_hi, done}, 3'b111);
        check("strobe_width", 64'(prev_strobe), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 64'd1, 64'd0);
        end else begin
          logic [EW-1:0] e;
          int due;
          e   = exp_q.pop_front();
          due = due_q.pop_front();
          check("result", {value_hi, value_lo, negative, overflow, carry, zero}, 64'(e));
          check("latency", 64'(edge_cnt), 64'(due));
        end
      end
      prev_strobe = write_lo;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  // Issue one operation; returns the accepting edge index.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit expect_result, output int acc);
    wait_idle();
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clock);
    #1;
    acc = edge_cnt;
    start = 1'b0;
    op = 2'($urandom); operand_a = 16'($urandom); operand_b = 16'($urandom);
    check("busy_after_accept", 64'(busy), 64'd1);
    if (expect_result) begin
      exp_q.push_back(ref_model(o, a, b));
      due_q.push_back(acc + 17);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    int n;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    reset = 1'b0; start = 1'b1; op = 2'b00; operand_a = 16'h0003; operand_b = 16'h0005;
    repeat (3) @(negedge clock);
    check("reset_outputs",
          {busy, done, write_lo, write_hi, value_hi, value_lo, negative, overflow, carry, zero},
          64'd0);
    reset = 1'b1; start = 1'b0;
    @(negedge clock);
    check("idle_after_reset", 64'(busy), 64'd0);

    // Directed cases
    issue(2'b00, 16'h1234, 16'h0010, 1'b1, acc);
    issue(2'b01, 16'hFFFE, 16'h0003, 1'b1, acc);
    issue(2'b10, 16'd100,  16'd7,    1'b1, acc);
    issue(2'b11, 16'hFFF9, 16'h0002, 1'b1, acc);
    issue(2'b10, 16'h1234, 16'h0000, 1'b1, acc);
    issue(2'b11, 16'h8000, 16'hFFFF, 1'b1, acc);
    issue(2'b11, 16'h8000, 16'h0000, 1'b1, acc);
    issue(2'b00, 16'h0000, 16'hBEEF, 1'b1, acc);
    issue(2'b01, 16'h8000, 16'h8000, 1'b1, acc);

    // Start pulsed during CALC and again during WRITE must be ignored
    issue(2'b01, 16'h7FFF, 16'h0002, 1'b1, acc);
    repeat (5) @(negedge clock);
    start = 1'b1; op = 2'b10; operand_a = 16'h0055; operand_b = 16'h0003;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
    start = 1'b1;  // sampled at the edge that closes WRITE
    @(negedge clock);
    start = 1'b0;
    check("write_start_ignored", 64'(busy), 64'd0);

    // Reset in the middle of CALC aborts with no strobe
    issue(2'b00, 16'hABCD, 16'h1357, 1'b0, acc);
    repeat (8) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("abort_outputs",
          {busy, done, write_lo, write_hi, value_hi, value_lo, negative, overflow, carry, zero},
          64'd0);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("abort_idle", 64'(busy), 64'd0);
    issue(2'b11, 16'hFFF9, 16'h0002, 1'b1, acc);

    // Randomized operations, biased toward the divide corner cases
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 16'h0000;
        1: begin ra = 16'h8000; rb = 16'hFFFF; end
        2: rb = 16'($urandom_range(1, 15));
        default: ;
      endcase
      issue(ro, ra, rb, 1'b1, acc);
    end

    // Drain the scoreboard
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
